// File: rtl/sqrt2_host.sv
// Host-side controller for one sqrt2 core: moves an operand onto the shared IO_DATA bus,
// waits for RESULT (or times out) and returns the captured word and flags on a valid/ready port.
module sqrt2_host #(
  parameter int LOAD_CYCLES    = 1,
  parameter int TURN_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  // Handshakes: a transfer happens on a rising CLK edge where valid and ready are both 1;
  // valid never waits on ready, and the payload is held stable while valid is 1.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_nan,
  output logic        rsp_pinf,
  output logic        rsp_ninf,
  output logic        rsp_timeout,
  inout  wire  [15:0] IO_DATA,
  output logic        ENABLE,
  input  logic        RESULT,
  input  logic        IS_NAN,
  input  logic        IS_PINF,
  input  logic        IS_NINF,
  output logic [2:0]  dbg_state
);

  localparam int MAX_LT  = (LOAD_CYCLES > TURN_CYCLES) ? LOAD_CYCLES : TURN_CYCLES;
  localparam int MAX_TG  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_LT > MAX_TG) ? MAX_LT : MAX_TG;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TURN = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic [15:0]   op_q;
  logic          accept, capture, abort;

  assign dbg_state = state_q;

  // The bus is only driven in LOAD, and backs off at once if the core claims it.
  assign IO_DATA = (state_q == S_LOAD && !RESULT) ? op_q : 16'hzzzz;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid && req_ready) begin
        accept  = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: if (cnt == LOAD_LAST) state_d = S_TURN;
      S_TURN: if (cnt == TURN_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (RESULT) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else if (cnt == TO_LAST) begin
          abort   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: if (rsp_valid && rsp_ready) state_d = S_GAP;
      S_GAP:  if (cnt == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_GAP;
    endcase
  end

  // Reset parks the FSM in GAP so the core gets a flush window before the first operand.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_GAP;
      cnt         <= '0;
      op_q        <= '0;
      ENABLE      <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_nan     <= 1'b0;
      rsp_pinf    <= 1'b0;
      rsp_ninf    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + CW'(1);
      ENABLE    <= (state_d == S_LOAD) || (state_d == S_TURN) || (state_d == S_WAIT);
      req_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_RESP);
      if (accept) op_q <= req_data;
      if (capture) begin
        rsp_data    <= IO_DATA;
        rsp_nan     <= IS_NAN;
        rsp_pinf    <= IS_PINF;
        rsp_ninf    <= IS_NINF;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_data    <= '0;
        rsp_nan     <= 1'b0;
        rsp_pinf    <= 1'b0;
        rsp_ninf    <= 1'b0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sqrt2_host.sv
// Bench for sqrt2_host: a behavioural sqrt2 core on the shared bus, a response scoreboard,
// a table of single transactions and hand-written stall / back-to-back / reset sequences.
module tb_sqrt2_host;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] req_data, rsp_data;
  logic        rsp_nan, rsp_pinf, rsp_ninf, rsp_timeout;
  wire  [15:0] io_data;
  logic        enable, result, is_nan, is_pinf, is_ninf;
  logic [2:0]  dbg_state;

  logic        core_drv;
  logic [15:0] core_val;
  int          core_delay;

  assign io_data = core_drv ? core_val : 16'hzzzz;

  sqrt2_host dut (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_nan(rsp_nan), .rsp_pinf(rsp_pinf), .rsp_ninf(rsp_ninf), .rsp_timeout(rsp_timeout),
    .IO_DATA(io_data), .ENABLE(enable), .RESULT(result),
    .IS_NAN(is_nan), .IS_PINF(is_pinf), .IS_NINF(is_ninf),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;
  logic [19:0] exp_q[$];   // {timeout, nan, pinf, ninf, data}
  logic [15:0] op_log[$];  // operands the core model saw on the bus

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: {nan, pinf, ninf, data} for each operand it knows about.
  function automatic logic [18:0] core_answer(input logic [15:0] op);
    case (op)
      16'h4400: core_answer = {3'b000, 16'h4000};
      16'hC000: core_answer = {3'b100, 16'h7E00};
      16'h7C00: core_answer = {3'b010, 16'h7C00};
      16'h3C00: core_answer = {3'b000, 16'h3C00};
      16'h4C00: core_answer = {3'b000, 16'h4400};
      16'h4880: core_answer = {3'b000, 16'h4200};
      16'h1234: core_answer = {3'b001, 16'hFC00};  // synthetic pattern for the -Inf flag path
      default:  core_answer = {3'b000, 16'h0000};
    endcase
  endfunction

  initial begin : core_model
    logic        busy;
    logic [15:0] cur_op;
    logic [18:0] ans;
    busy = 1'b0;
    core_drv = 1'b0; core_val = '0;
    result = 1'b0; is_nan = 1'b0; is_pinf = 1'b0; is_ninf = 1'b0;
    forever begin
      @(negedge clk);
      if (!enable) busy = 1'b0;
      else if (!busy) begin
        busy = 1'b1;
        cur_op = io_data;
        op_log.push_back(cur_op);
        if (core_delay != 0) begin
          repeat (core_delay) @(negedge clk);
          ans = core_answer(cur_op);
          core_val = ans[15:0];
          {is_nan, is_pinf, is_ninf} = ans[18:16];
          core_drv = 1'b1; result = 1'b1;
          @(negedge clk);
          core_drv = 1'b0; result = 1'b0;
          {is_nan, is_pinf, is_ninf} = 3'b000;
        end
      end
    end
  end

  always @(negedge clk) begin : scoreboard
    if (rsp_valid && rsp_ready) begin
      rsp_seen++;
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else chk("rsp_payload", {12'd0, rsp_timeout, rsp_nan, rsp_pinf, rsp_ninf, rsp_data},
               {12'd0, exp_q.pop_front()});
    end
  end

  logic track_gap = 1'b0;
  int   low_run, min_low;
  logic seen_hi;
  always @(negedge clk) begin : enable_gap_monitor
    if (track_gap) begin
      if (!enable) low_run++;
      else begin
        if (seen_hi && low_run > 0 && low_run < min_low) min_low = low_run;
        low_run = 0;
        seen_hi = 1'b1;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_req(input logic [15:0] d, input logic [19:0] exp);
    int t = 0;
    req_valid = 1'b1;
    req_data  = d;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk("req_accept_timeout", 32'd0, 32'd1);
    else exp_q.push_back(exp);
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = $urandom_range(0, 16'hFFFF);
  endtask

  task automatic wait_rsp(input int n);
    int t = 0;
    while (rsp_seen < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (rsp_seen < n) chk("rsp_wait_timeout", rsp_seen, n);
  endtask

  typedef struct {
    logic [15:0] op;
    int          delay;
    logic [15:0] data;
    logic        nan, pinf, ninf, tmo;
    int          lat;
  } vec_t;

  vec_t vecs[9];
  logic [15:0] b2b_ops[4];
  logic [19:0] b2b_exp[4];
  int acc_t[4];

  initial begin : test
    int lat, cyc, n, ok;
    logic [15:0] snap;
    // Latency from accept edge: core raises RESULT d negedges after LOAD -> rsp_valid d+1 edges later;
    // a silent core (or a pulse only in TURN) aborts after 1 LOAD + 1 TURN + 64 WAIT edges.
    vecs[0] = '{16'h4400, 5, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 6};
    vecs[1] = '{16'hC000, 4, 16'h7E00, 1'b1, 1'b0, 1'b0, 1'b0, 5};
    vecs[2] = '{16'h3C00, 2, 16'h3C00, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[3] = '{16'h4C00, 7, 16'h4400, 1'b0, 1'b0, 1'b0, 1'b0, 8};
    vecs[4] = '{16'h4880, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 66};
    vecs[5] = '{16'h4400, 1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 66};
    vecs[6] = '{16'h7C00, 3, 16'h7C00, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[7] = '{16'h1234, 6, 16'hFC00, 1'b0, 1'b0, 1'b1, 1'b0, 7};
    vecs[8] = '{16'h4880, 2, 16'h4200, 1'b0, 1'b0, 1'b0, 1'b0, 3};

    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; rsp_ready = 1'b1; core_delay = 0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_enable", enable, 0);
    chk("reset_rsp_data", {rsp_timeout, rsp_nan, rsp_pinf, rsp_ninf, rsp_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_gap", req_ready, 0);
    @(negedge clk);
    chk("post_reset_idle", req_ready, 1);

    for (int i = 0; i < 9; i++) begin
      core_delay = vecs[i].delay;
      op_log.delete();
      n = rsp_seen;
      send_req(vecs[i].op, {vecs[i].tmo, vecs[i].nan, vecs[i].pinf, vecs[i].ninf, vecs[i].data});
      lat = 0;
      while (!rsp_valid && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("latency_%0d", i), lat, vecs[i].lat);
      wait_rsp(n + 1);
      if (op_log.size() == 0) chk($sformatf("bus_op_%0d", i), 32'd0, 32'd1);
      else chk($sformatf("bus_op_%0d", i), op_log[0], vecs[i].op);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Stalled consumer: response must hold and the core must stay disabled.
    rsp_ready = 1'b0;
    core_delay = 4;
    n = rsp_seen;
    send_req(16'h7C00, {1'b0, 3'b010, 16'h7C00});
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    snap = rsp_data;
    ok = 1;
    repeat (10) begin
      if (!rsp_valid || enable || rsp_data !== snap || !rsp_pinf || rsp_nan || rsp_timeout) ok = 0;
      @(negedge clk);
    end
    chk("stall_stable", ok, 1);
    chk("stall_data", snap, 16'h7C00);
    rsp_ready = 1'b1;
    wait_rsp(n + 1);

    // Back-to-back with req_valid held: accept -> rsp_valid (4) + handshake (1) + GAP (2) + IDLE (1).
    b2b_ops = '{16'h4400, 16'hC000, 16'h3C00, 16'h4C00};
    b2b_exp = '{{4'b0000, 16'h4000}, {4'b0100, 16'h7E00}, {4'b0000, 16'h3C00}, {4'b0000, 16'h4400}};
    core_delay = 3;
    op_log.delete();
    low_run = 0; min_low = 1000; seen_hi = 1'b0; track_gap = 1'b1;
    n = rsp_seen;
    req_valid = 1'b1;
    req_data = b2b_ops[0];
    cyc = 0;
    begin
      int k = 0;
      while (k < 4 && cyc < 400) begin
        if (req_ready) begin
          exp_q.push_back(b2b_exp[k]);
          acc_t[k] = cyc;
          k++;
        end
        @(negedge clk);
        cyc++;
        if (k < 4) req_data = b2b_ops[k];
      end
      if (k < 4) chk("b2b_accepts", k, 4);
    end
    req_valid = 1'b0;
    wait_rsp(n + 4);
    track_gap = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_period_%0d", i), acc_t[i+1] - acc_t[i], 8);
    chk("b2b_enable_gap", (min_low >= GAP && min_low < 1000), 1);
    if (op_log.size() != 4) chk("b2b_bus_count", op_log.size(), 4);
    else for (int i = 0; i < 4; i++) chk($sformatf("b2b_bus_op_%0d", i), op_log[i], b2b_ops[i]);

    // Reset while waiting on a silent core.
    core_delay = 0;
    send_req(16'h4400, 20'd0);
    cyc = 0;
    while (dbg_state != 3'd3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_wait", dbg_state, 3'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_enable", enable, 0);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_req_ready", req_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_gap", req_ready, 0);
    @(negedge clk);
    chk("midreset_idle", req_ready, 1);
    core_delay = 5;
    n = rsp_seen;
    send_req(16'h4400, {4'b0000, 16'h4000});
    wait_rsp(n + 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
